// File: rtl/demux_buf.sv
// -----------------------------------------------------------------------------
// demux_buf
//
// Registered 1-to-2 demultiplexer. A W-bit word arriving on the input
// valid/ready channel is steered by in_select into one of two per-channel
// FIFOs (DEPTH entries each). Each FIFO drains through its own valid/ready
// output channel, and a wrap-around counter per channel records how many words
// have been delivered on it.
//
// Handshake semantics (all channels): a transfer happens at a rising clock
// edge where valid and ready are both 1. Neither side may make valid depend
// combinationally on ready. in_ready depends only on the state of the FIFO
// that in_select currently points at. Nothing transfers in a cycle with rst=1.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input channel handshake
//   in_select                destination channel (0 or 1)
//   in_data [W-1:0]          input word
//   out0_valid/out0_ready    channel 0 output handshake
//   out0_data [W-1:0]        channel 0 head word (0 when empty)
//   out1_valid/out1_ready    channel 1 output handshake
//   out1_data [W-1:0]        channel 1 head word (0 when empty)
//   cnt0, cnt1 [CNT_W-1:0]   words delivered per channel, wrapping
// -----------------------------------------------------------------------------
module demux_buf #(
    parameter int W     = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_select,
    input  logic [W-1:0]     in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [W-1:0]     out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [W-1:0]     out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = PW + 1;

    logic [W-1:0]     mem_q    [2][DEPTH];
    logic [W-1:0]     mem_d    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [OW-1:0]    occ_q    [2];
    logic [OW-1:0]    occ_d    [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];

    logic [1:0] full;
    logic [1:0] not_empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready_v;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]      = (occ_q[c] == OW'(DEPTH));
            not_empty[c] = (occ_q[c] != '0);
        end
    end

    // A full FIFO refuses the push even if it pops this cycle: no slot reuse.
    assign in_ready = !full[in_select];

    always_comb begin
        out_ready_v = {out1_ready, out0_ready};
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        cnt_d       = cnt_q;
        push        = '0;
        pop         = '0;
        for (int c = 0; c < 2; c++) begin
            // in_valid gates everything, so X on in_select/in_data while idle
            // never reaches the state.
            push[c] = in_valid && in_ready && (in_select == 1'(c));
            pop[c]  = not_empty[c] && out_ready_v[c];
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = in_data;
                wr_ptr_d[c]           = wr_ptr_q[c] + PW'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
                cnt_d[c]    = cnt_q[c] + CNT_W'(1);
            end
            case ({push[c], pop[c]})
                2'b10:   occ_d[c] = occ_q[c] + OW'(1);
                2'b01:   occ_d[c] = occ_q[c] - OW'(1);
                default: occ_d[c] = occ_q[c];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '{default: '0}};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            occ_q    <= '{default: '0};
            cnt_q    <= '{default: '0};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out0_valid = not_empty[0];
    assign out1_valid = not_empty[1];
    assign out0_data  = not_empty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign out1_data  = not_empty[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];

endmodule
